controle_multiciclo_param: RTL and testbench

//  Parametrised multicycle MIPS control FSM driving the existing datapath mux/enable signals.

---
 rtl/ctrl_pkg.sv | 81 ++++++++
 rtl/ctrl_wait_counter.sv | 27 ++
 rtl/controle_multiciclo_param.sv | 224 ++++++++++++++++++++++
 tb/tb_controle_multiciclo_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the parametrised multicycle MIPS controller.
package ctrl_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned WAIT_W  = $clog2(8);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 5'd0,
    S_FETCH_WR = 5'd1,
    S_DECODE   = 5'd2,
    S_EXEC_R   = 5'd3,
    S_WB_R     = 5'd4,
    S_EXEC_I   = 5'd5,
    S_WB_I     = 5'd6,
    S_ADDR     = 5'd7,
    S_MEM_RD   = 5'd8,
    S_MEM_WB   = 5'd9,
    S_MEM_WR   = 5'd10,
    S_BRANCH   = 5'd11,
    S_JUMP     = 5'd12,
    S_EXC_SAVE = 5'd13,
    S_EXC_JUMP = 5'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [2:0] PCS_ALU    = 3'b000;
  localparam logic [2:0] PCS_ALUOUT = 3'b001;
  localparam logic [2:0] PCS_JUMP   = 3'b010;
  localparam logic [2:0] PCS_EXC    = 3'b011;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;

  localparam logic [2:0] REGDST_RT = 3'b000;
  localparam logic [2:0] REGDST_RD = 3'b001;

  localparam logic [3:0] DSRC_ALUOUT = 4'b0000;
  localparam logic [3:0] DSRC_MDR    = 4'b0001;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;

  // R-type functs this controller can execute.
  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND);
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Wait-state counter: counts cycles spent in the current state; done once the limit is reached.
module ctrl_wait_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = (cnt == limit);

  // Cleared whenever the FSM leaves a state so the next state starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/controle_multiciclo_param.sv
// Multicycle MIPS control FSM with configurable memory/decode wait states and EPC exceptions.
module controle_multiciclo_param
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned DEC_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       MemCtrl,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       SEControl,
  output logic       A_Control,
  output logic       B_Control,
  output logic       RegControl,
  output logic       ALUOutControl,
  output logic       EPCWrite,
  output logic [1:0] IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] RegDst,
  output logic [2:0] PCSource,
  output logic [2:0] ALUControl,
  output logic [3:0] DataSrc,
  output logic [1:0] ExcCause,
  output logic [4:0] state_dbg
);

  localparam logic [WAIT_W-1:0] MEM_LIM = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] DEC_LIM = WAIT_W'(DEC_WAIT);

  state_e            state;
  state_e            state_nxt;
  logic              set_cause;
  logic [1:0]        cause_nxt;
  logic [WAIT_W-1:0] wait_limit;
  logic              wait_done;

  assign state_dbg = 5'(state);

  // Only the memory and decode states stretch; every other state is single-cycle.
  always_comb begin
    wait_limit = '0;
    case (state)
      S_FETCH, S_MEM_RD, S_MEM_WR: wait_limit = MEM_LIM;
      S_DECODE:                    wait_limit = DEC_LIM;
      default:                     wait_limit = '0;
    endcase
  end

  ctrl_wait_counter #(.W(WAIT_W)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (state_nxt != state),
    .limit (wait_limit),
    .done  (wait_done)
  );

  always_comb begin
    state_nxt = state;
    set_cause = 1'b0;
    cause_nxt = CAUSE_NONE;
    case (state)
      S_FETCH:    if (wait_done) state_nxt = S_FETCH_WR;
      S_FETCH_WR: state_nxt = S_DECODE;
      S_DECODE: begin
        if (wait_done) begin
          if (OpCode == OP_RTYPE && funct_supported(funct)) begin
            state_nxt = S_EXEC_R;
          end else if (OpCode == OP_ADDI) begin
            state_nxt = S_EXEC_I;
          end else if (OpCode == OP_LW || OpCode == OP_SW) begin
            state_nxt = S_ADDR;
          end else if (OpCode == OP_BEQ || OpCode == OP_BNE) begin
            state_nxt = S_BRANCH;
          end else if (OpCode == OP_J) begin
            state_nxt = S_JUMP;
          end else begin
            state_nxt = S_EXC_SAVE;
            set_cause = 1'b1;
            cause_nxt = CAUSE_OPC;
          end
        end
      end
      S_EXEC_R: begin
        if (Overflow && funct != FN_AND) begin
          state_nxt = S_EXC_SAVE;
          set_cause = 1'b1;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = S_WB_R;
        end
      end
      S_EXEC_I: begin
        if (Overflow) begin
          state_nxt = S_EXC_SAVE;
          set_cause = 1'b1;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = S_WB_I;
        end
      end
      S_ADDR:     state_nxt = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (wait_done) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (wait_done) state_nxt = S_FETCH;
      S_EXC_SAVE: state_nxt = S_EXC_JUMP;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_EXC_JUMP:
        state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Cause is captured on the way into EXC_SAVE and held until the next exception.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      ExcCause <= CAUSE_NONE;
    end else begin
      state <= state_nxt;
      if (set_cause) ExcCause <= cause_nxt;
    end
  end

  // Moore decode from the state register; only the branch PCWrite qualifies on Zero.
  always_comb begin
    PCWrite       = 1'b0;
    MemCtrl       = 1'b0;
    IRWrite       = 1'b0;
    MDRWrite      = 1'b0;
    SEControl     = 1'b0;
    A_Control     = 1'b0;
    B_Control     = 1'b0;
    RegControl    = 1'b0;
    ALUOutControl = 1'b0;
    EPCWrite      = 1'b0;
    IorD          = IORD_PC;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_B;
    RegDst        = REGDST_RT;
    PCSource      = PCS_ALU;
    ALUControl    = ALU_NONE;
    DataSrc       = DSRC_ALUOUT;
    case (state)
      S_FETCH_WR: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_4;
        ALUControl = ALU_ADD;
      end
      S_DECODE: begin
        SEControl     = 1'b1;
        ALUSrcB       = SRCB_IMM4;
        ALUControl    = ALU_ADD;
        A_Control     = wait_done;
        B_Control     = wait_done;
        ALUOutControl = wait_done;
      end
      S_EXEC_R: begin
        ALUSrcA       = SRCA_A;
        ALUSrcB       = SRCB_B;
        ALUControl    = alu_for_funct(funct);
        ALUOutControl = 1'b1;
      end
      S_WB_R: begin
        RegControl = 1'b1;
        RegDst     = REGDST_RD;
        DataSrc    = DSRC_ALUOUT;
      end
      S_EXEC_I, S_ADDR: begin
        ALUSrcA       = SRCA_A;
        ALUSrcB       = SRCB_IMM;
        ALUControl    = ALU_ADD;
        ALUOutControl = 1'b1;
      end
      S_WB_I: begin
        RegControl = 1'b1;
        RegDst     = REGDST_RT;
      end
      S_MEM_RD: begin
        IorD     = IORD_ALUOUT;
        MDRWrite = wait_done;
      end
      S_MEM_WB: begin
        RegControl = 1'b1;
        RegDst     = REGDST_RT;
        DataSrc    = DSRC_MDR;
      end
      S_MEM_WR: begin
        IorD    = IORD_ALUOUT;
        MemCtrl = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUControl = ALU_SUB;
        PCSource   = PCS_ALUOUT;
        PCWrite    = Zero ^ (OpCode == OP_BNE);
      end
      S_JUMP: begin
        PCSource = PCS_JUMP;
        PCWrite  = 1'b1;
      end
      S_EXC_SAVE: begin
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_4;
        ALUControl = ALU_SUB;
        EPCWrite   = 1'b1;
      end
      S_EXC_JUMP: begin
        PCSource = PCS_EXC;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo_param.sv
// Directed bench for controle_multiciclo_param: three instances with different wait-state settings.
module tb_controle_multiciclo_param;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, fn;
  logic       zero, ovf;

  logic       pcw[3], memc[3], irw[3], mdrw[3], sec[3], ac[3], bc[3], regc[3], aluoc[3], epcw[3];
  logic [1:0] iord[3], srca[3], srcb[3], cause[3];
  logic [2:0] regdst[3], pcs[3], aluc[3];
  logic [3:0] dsrc[3];
  logic [4:0] st[3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: MEM_WAIT=2/DEC_WAIT=1, instance 1: 0/0, instance 2: 3/1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    controle_multiciclo_param #(
      .MEM_WAIT((g == 0) ? 2 : ((g == 1) ? 0 : 3)),
      .DEC_WAIT((g == 1) ? 0 : 1)
    ) u_dut (
      .clk           (clk),
      .reset         (rst),
      .OpCode        (op),
      .funct         (fn),
      .Zero          (zero),
      .Overflow      (ovf),
      .PCWrite       (pcw[g]),
      .MemCtrl       (memc[g]),
      .IRWrite       (irw[g]),
      .MDRWrite      (mdrw[g]),
      .SEControl     (sec[g]),
      .A_Control     (ac[g]),
      .B_Control     (bc[g]),
      .RegControl    (regc[g]),
      .ALUOutControl (aluoc[g]),
      .EPCWrite      (epcw[g]),
      .IorD          (iord[g]),
      .ALUSrcA       (srca[g]),
      .ALUSrcB       (srcb[g]),
      .RegDst        (regdst[g]),
      .PCSource      (pcs[g]),
      .ALUControl    (aluc[g]),
      .DataSrc       (dsrc[g]),
      .ExcCause      (cause[g]),
      .state_dbg     (st[g])
    );
  end

  logic [9:0] strb0;
  assign strb0 = {pcw[0], memc[0], irw[0], mdrw[0], sec[0], ac[0], bc[0], regc[0], aluoc[0], epcw[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 of FETCH with reset released.
  task automatic reset_all();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_state", 32'(st[0]), 32'(S_FETCH));
    check("rst_strobes", 32'(strb0), 32'h0);
    check("rst_cause", 32'(cause[0]), 32'h0);
    rst = 1'b0;
  endtask

  // Runs one instruction from reset on all instances and counts per-state cycles.
  task automatic measure(input string tag, input logic [5:0] opc, input bit is_lw);
    int nf[3], nd[3], nm[3], nmc[3], nmd[3], nwb[3];
    bit seen[3], fin[3];
    int ef[3], ed[3], em[3];
    ef = '{3, 1, 4};
    ed = '{2, 1, 2};
    em = '{3, 1, 4};
    for (int i = 0; i < 3; i++) begin
      nf[i] = 0; nd[i] = 0; nm[i] = 0; nmc[i] = 0; nmd[i] = 0; nwb[i] = 0;
      seen[i] = 1'b0; fin[i] = 1'b0;
    end
    op = opc;
    fn = 6'b000000;
    reset_all();
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!fin[i]) begin
          if (st[i] == 5'(S_FETCH)) begin
            if (seen[i]) fin[i] = 1'b1;
            else nf[i]++;
          end
          if (st[i] == 5'(S_FETCH_WR)) seen[i] = 1'b1;
          if (st[i] == 5'(S_DECODE)) nd[i]++;
          if (st[i] == 5'(S_MEM_RD) || st[i] == 5'(S_MEM_WR)) nm[i]++;
          if (!fin[i]) begin
            nmc[i] += int'(memc[i]);
            nmd[i] += int'(mdrw[i]);
          end
          if (st[i] == 5'(S_MEM_WB) && dsrc[i] == 4'b0001 && regc[i]) nwb[i]++;
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_done%0d", tag, i), 32'(fin[i]), 32'd1);
      check($sformatf("%s_fetch%0d", tag, i), 32'(nf[i]), 32'(ef[i]));
      check($sformatf("%s_dec%0d", tag, i), 32'(nd[i]), 32'(ed[i]));
      check($sformatf("%s_mem%0d", tag, i), 32'(nm[i]), 32'(em[i]));
      check($sformatf("%s_memctrl%0d", tag, i), 32'(nmc[i]), is_lw ? 32'd0 : 32'(em[i]));
      check($sformatf("%s_mdrw%0d", tag, i), 32'(nmd[i]), is_lw ? 32'd1 : 32'd0);
      check($sformatf("%s_wbmdr%0d", tag, i), 32'(nwb[i]), is_lw ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op = OP_RTYPE; fn = FN_ADD; zero = 1'b0; ovf = 1'b0;
    reset_all();

    // add, no overflow: writeback in cycle 8 after FETCH entry
    check("add_c1", 32'(st[0]), 32'(S_FETCH));
    tick(); tick();
    check("add_c3", 32'(st[0]), 32'(S_FETCH));
    check("add_c3_iord", 32'(iord[0]), 32'h0);
    tick();
    check("add_fwr", 32'(st[0]), 32'(S_FETCH_WR));
    check("add_fwr_ctl", {irw[0], pcw[0], srca[0], srcb[0], aluc[0]}, {2'b11, 2'b00, 2'b01, 3'b001});
    tick();
    check("add_dec1_abo", {ac[0], bc[0], aluoc[0]}, 3'b000);
    check("add_dec1_se", {sec[0], srcb[0], aluc[0]}, {1'b1, 2'b11, 3'b001});
    tick();
    check("add_dec2_abo", {ac[0], bc[0], aluoc[0]}, 3'b111);
    tick();
    check("add_exec", 32'(st[0]), 32'(S_EXEC_R));
    check("add_exec_ctl", {srca[0], srcb[0], aluc[0], aluoc[0]}, {2'b01, 2'b00, 3'b001, 1'b1});
    tick();
    check("add_wb_ctl", {regc[0], regdst[0], dsrc[0]}, {1'b1, 3'b001, 4'b0000});
    check("add_wb_cause", 32'(cause[0]), 32'h0);
    tick();
    check("add_back_fetch", 32'(st[0]), 32'(S_FETCH));

    // sub with overflow -> exception
    fn = FN_SUB; ovf = 1'b1;
    repeat (6) tick();
    check("sub_exec_alu", 32'(aluc[0]), 32'h2);
    tick();
    check("sub_exc_state", 32'(st[0]), 32'(S_EXC_SAVE));
    check("sub_no_regc", 32'(regc[0]), 32'h0);
    check("sub_exc_save", {epcw[0], srca[0], srcb[0], aluc[0]}, {1'b1, 2'b00, 2'b01, 3'b010});
    check("sub_cause", 32'(cause[0]), 32'h2);
    tick();
    check("sub_exc_jump", {pcw[0], pcs[0], epcw[0]}, {1'b1, 3'b011, 1'b0});
    tick();
    check("sub_after", 32'(st[0]), 32'(S_FETCH));
    check("sub_cause_hold", 32'(cause[0]), 32'h2);

    // and ignores overflow
    fn = FN_AND;
    repeat (6) tick();
    check("and_exec_alu", 32'(aluc[0]), 32'h3);
    tick();
    check("and_wb", 32'(st[0]), 32'(S_WB_R));
    check("and_cause_hold", 32'(cause[0]), 32'h2);
    tick();
    ovf = 1'b0;

    // unsupported funct -> bad opcode
    fn = 6'b000000;
    repeat (6) tick();
    check("badfn_exc", 32'(st[0]), 32'(S_EXC_SAVE));
    check("badfn_cause", 32'(cause[0]), 32'h1);
    repeat (2) tick();

    // addi, no overflow then overflow
    op = OP_ADDI;
    repeat (6) tick();
    check("addi_exec", {srca[0], srcb[0], aluc[0], aluoc[0]}, {2'b01, 2'b10, 3'b001, 1'b1});
    tick();
    check("addi_wb", {regc[0], regdst[0], dsrc[0]}, {1'b1, 3'b000, 4'b0000});
    check("addi_wb_state", 32'(st[0]), 32'(S_WB_I));
    tick();
    ovf = 1'b1;
    repeat (7) tick();
    check("addi_ovf_exc", 32'(st[0]), 32'(S_EXC_SAVE));
    check("addi_ovf_cause", 32'(cause[0]), 32'h2);
    repeat (2) tick();
    ovf = 1'b0;

    // invalid opcode straight from DECODE
    op = 6'b111111;
    repeat (6) tick();
    check("badop_exc", {st[0], epcw[0]}, {5'(S_EXC_SAVE), 1'b1});
    check("badop_cause", 32'(cause[0]), 32'h1);
    tick();
    check("badop_jump", {pcw[0], pcs[0]}, {1'b1, 3'b011});
    tick();

    // jump
    op = OP_J;
    repeat (6) tick();
    check("j_ctl", {st[0], pcw[0], pcs[0]}, {5'(S_JUMP), 1'b1, 3'b010});
    tick();

    // branches
    op = OP_BEQ; zero = 1'b1;
    repeat (6) tick();
    check("beq_taken", {pcw[0], pcs[0], srca[0], srcb[0], aluc[0]}, {1'b1, 3'b001, 2'b01, 2'b00, 3'b010});
    tick();
    zero = 1'b0;
    repeat (6) tick();
    check("beq_not_taken", 32'(pcw[0]), 32'h0);
    tick();
    op = OP_BNE;
    repeat (6) tick();
    check("bne_taken", 32'(pcw[0]), 32'h1);
    tick();
    zero = 1'b1;
    repeat (6) tick();
    check("bne_not_taken", 32'(pcw[0]), 32'h0);
    tick();
    check("bne_back_fetch", 32'(st[0]), 32'(S_FETCH));
    zero = 1'b0;

    // wait-state scaling for loads and stores
    measure("lw", OP_LW, 1'b1);
    measure("sw", OP_SW, 1'b0);

    // reset in the middle of a store
    op = OP_SW;
    reset_all();
    repeat (7) tick();
    check("rst_mw_before", {st[0], memc[0], iord[0]}, {5'(S_MEM_WR), 1'b1, 2'b01});
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mw_memctrl", 32'(memc[0]), 32'h0);
    check("rst_mw_state", 32'(st[0]), 32'(S_FETCH));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mw_strobes", 32'(strb0), 32'h0);
    tick(); tick();
    check("rst_mw_fetch3", 32'(st[0]), 32'(S_FETCH));
    tick();
    check("rst_mw_fwr", 32'(st[0]), 32'(S_FETCH_WR));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
